// File: rtl/sum_fact_param.sv
// rtl/sum_fact_param.sv - iterative N!/sum k!/sum k/sum k^2 engine with sticky overflow (optional SUM_FACT_SATURATE_EN)
module sum_fact_param #(
    parameter int N_W   = 4,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_W-1:0]   n_in,
    input  logic [1:0]       mode_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ack,
    output logic [RES_W-1:0] result,
    output logic             overflow,
    output logic             out_valid,
    output logic             busy
);

    localparam int W = RES_W + N_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] MODE_FACT   = 2'd0;
    localparam logic [1:0] MODE_SUMF   = 2'd1;
    localparam logic [1:0] MODE_SUMK   = 2'd2;
    localparam logic [1:0] MODE_SUMKSQ = 2'd3;

    logic [1:0]       state;
    logic [N_W-1:0]   n_reg;
    logic [1:0]       mode_reg;
    logic [N_W-1:0]   k;
    logic [RES_W-1:0] f;
    logic [RES_W-1:0] s;
    logic             ovf;

    logic [W-1:0]     f_w;
    logic [W-1:0]     k_w;
    logic [W-1:0]     s_w;
    logic [W-1:0]     f_prod;
    logic [W-1:0]     term;
    logic [W-1:0]     s_sum;
    logic             f_ovf;
    logic             s_ovf;
    logic             ovf_next;
    logic [RES_W-1:0] f_next;
    logic [RES_W-1:0] s_next;

    // One series term, evaluated RES_W+N_W wide so any carry above RES_W is visible.
    always_comb begin
        f_w    = {{N_W{1'b0}}, f};
        k_w    = {{RES_W{1'b0}}, k};
        s_w    = {{N_W{1'b0}}, s};
        f_prod = f_w * k_w;
        case (mode_reg)
            MODE_SUMF:   term = {{N_W{1'b0}}, f_prod[RES_W-1:0]};
            MODE_SUMK:   term = k_w;
            MODE_SUMKSQ: term = k_w * k_w;
            default:     term = '0;
        endcase
        s_sum    = s_w + term;
        f_ovf    = !mode_reg[1] && (|f_prod[W-1:RES_W]);
        s_ovf    = (mode_reg != MODE_FACT) && (|s_sum[W-1:RES_W]);
        ovf_next = ovf | f_ovf | s_ovf;
        f_next   = f_prod[RES_W-1:0];
        s_next   = (mode_reg == MODE_FACT) ? s : s_sum[RES_W-1:0];
`ifdef SUM_FACT_SATURATE_EN
        // Sticky ovf pins the reported accumulator at all ones for the rest of the job.
        if (ovf_next) begin
            if (mode_reg == MODE_FACT) begin
                f_next = '1;
            end else begin
                s_next = '1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            n_reg    <= '0;
            mode_reg <= '0;
            k        <= '0;
            f        <= '0;
            s        <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_reg    <= n_in;
                        mode_reg <= mode_in;
                        f        <= RES_W'(1);
                        s        <= '0;
                        k        <= N_W'(1);
                        ovf      <= 1'b0;
                        state    <= (n_in != '0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    f   <= f_next;
                    s   <= s_next;
                    ovf <= ovf_next;
                    k   <= k + N_W'(1);
                    if (k == n_reg) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign result    = out_valid ? ((mode_reg == MODE_FACT) ? f : s) : '0;
    assign overflow  = out_valid & ovf;

endmodule

// File: tb/tb_sum_fact_param.sv
// tb/tb_sum_fact_param.sv - vector table plus scoreboard bench for sum_fact_param
module tb_sum_fact_param;

    localparam int N_W   = 4;
    localparam int RES_W = 32;

`ifdef SUM_FACT_SATURATE_EN
    localparam logic [31:0] EXP13 = 32'hFFFF_FFFF;
    localparam bit          SAT   = 1'b1;
`else
    localparam logic [31:0] EXP13 = 32'd1932053504;
    localparam bit          SAT   = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [N_W-1:0]   n_in;
    logic [1:0]       mode_in;
    logic             in_valid;
    logic             in_ready;
    logic             out_ack;
    logic [RES_W-1:0] result;
    logic             overflow;
    logic             out_valid;
    logic             busy;

    sum_fact_param #(.N_W(N_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .n_in      (n_in),
        .mode_in   (mode_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ack   (out_ack),
        .result    (result),
        .overflow  (overflow),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  n;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          n;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Independent reference: 64-bit running values, flag anything at or above 2^32.
    task automatic model(input logic [1:0] m, input int n, output logic [31:0] r, output logic o);
        longint unsigned f = 1;
        longint unsigned s = 0;
        longint unsigned lim = 64'h1_0000_0000;
        o = 1'b0;
        for (int kk = 1; kk <= n; kk++) begin
            f = f * kk;
            if (m < 2 && f >= lim) o = 1'b1;
            f = f % lim;
            if (m == 1) s = s + f;
            if (m == 2) s = s + kk;
            if (m == 3) s = s + kk * kk;
            if (m != 0 && s >= lim) o = 1'b1;
            s = s % lim;
            if (SAT && o) begin
                if (m == 0) f = lim - 1;
                else        s = lim - 1;
            end
        end
        r = (m == 0) ? f[31:0] : s[31:0];
    endtask

    task automatic start_job(input logic [1:0] m, input logic [3:0] n, input logic [31:0] r, input logic o);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_job", in_ready, 1);
        n_in     = n;
        mode_in  = m;
        in_valid = 1'b1;
        sbq.push_back('{res: r, ovf: o, n: int'(n)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the acceptance edge; out_valid must rise exactly N edges later.
    task automatic wait_done(input int n);
        int cycles = 0;
        int busy_cnt = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, n);
        check("busy_cycles", busy_cnt, n);
    endtask

    task automatic collect();
        exp_t e;
        check("out_valid_at_collect", out_valid, 1);
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            check("result", result, e.res);
            check("overflow", overflow, e.ovf);
        end
    endtask

    task automatic ack();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("in_ready_after_ack", in_ready, 1);
        check("out_valid_after_ack", out_valid, 0);
        check("result_zero_idle", result, 0);
    endtask

    task automatic run_job(input logic [1:0] m, input logic [3:0] n, input logic [31:0] r, input logic o);
        start_job(m, n, r, o);
        wait_done(int'(n));
        collect();
        ack();
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] mr;
        logic        mo;
        logic [1:0]  rm;
        logic [3:0]  rn;

        vecs[0]  = '{mode: 2'd0, n: 4'd5,  res: 32'd120,       ovf: 1'b0};
        vecs[1]  = '{mode: 2'd1, n: 4'd3,  res: 32'd9,         ovf: 1'b0};
        vecs[2]  = '{mode: 2'd2, n: 4'd15, res: 32'd120,       ovf: 1'b0};
        vecs[3]  = '{mode: 2'd3, n: 4'd4,  res: 32'd30,        ovf: 1'b0};
        vecs[4]  = '{mode: 2'd0, n: 4'd0,  res: 32'd1,         ovf: 1'b0};
        vecs[5]  = '{mode: 2'd1, n: 4'd0,  res: 32'd0,         ovf: 1'b0};
        vecs[6]  = '{mode: 2'd0, n: 4'd13, res: EXP13,         ovf: 1'b1};
        vecs[7]  = '{mode: 2'd1, n: 4'd12, res: 32'd522956313, ovf: 1'b0};
        vecs[8]  = '{mode: 2'd2, n: 4'd0,  res: 32'd0,         ovf: 1'b0};
        vecs[9]  = '{mode: 2'd3, n: 4'd15, res: 32'd1240,      ovf: 1'b0};
        vecs[10] = '{mode: 2'd0, n: 4'd1,  res: 32'd1,         ovf: 1'b0};

        reset_n  = 1'b0;
        n_in     = '0;
        mode_in  = '0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Stray ack while idle must not disturb anything.
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("idle_ack_in_ready", in_ready, 1);
        check("idle_ack_out_valid", out_valid, 0);

        for (int i = 0; i < 11; i++) begin
            run_job(vecs[i].mode, vecs[i].n, vecs[i].res, vecs[i].ovf);
        end

        // Hold DONE for 10 cycles with competing input offered.
        start_job(2'd3, 4'd4, 32'd30, 1'b0);
        wait_done(4);
        held = result;
        collect();
        for (int i = 0; i < 10; i++) begin
            n_in     = 4'd9;
            mode_in  = 2'd0;
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_result", result, held);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        ack();
        run_job(2'd2, 4'd5, 32'd15, 1'b0);

        // Reset during the third BUSY cycle aborts the job.
        n_in     = 4'd7;
        mode_in  = 2'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        @(negedge clk);
        check("abort_stays_idle", out_valid, 0);
        run_job(2'd0, 4'd3, 32'd6, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rm = 2'($urandom_range(0, 3));
            rn = 4'($urandom_range(0, 15));
            model(rm, int'(rn), mr, mo);
            run_job(rm, rn, mr, mo);
        end

        check("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_fact_param.md
Name: sum_fact_param

Overview:
- Parametrised successor to the fixed 3-bit factorial-sum engine.
- Iteratively evaluates one of four series over k = 1..N, one term per clock. Modes: N!, sum of k!, sum of k, sum of k².
- Input side uses a valid/ready handshake; output side uses valid/ack.
- Detects overflow against a configurable result width. Sits between the operand sequencer and the result collector.

Parameters:
- N_W, 4, width of operand N; max N = 2^N_W-1
- RES_W, 32, width of result and internal accumulators

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- n_in  input  N_W  operand N
- mode_in  input  2  0 = N!, 1 = sum k!, 2 = sum k, 3 = sum k²
- in_valid  input  1  operand/mode offered
- in_ready  output  1  block can accept; high only in IDLE
- out_ack  input  1  collector consumed result
- result  output  RES_W  series value; 0 when out_valid low
- overflow  output  1  result exceeded RES_W bits; 0 when out_valid low
- out_valid  output  1  result/overflow valid; high only in DONE
- busy  output  1  high in BUSY

Behaviour:
- Single clock. Reset is synchronous, active-low. All state updates on the rising edge of clk.
- Reset (reset_n = 0 at an edge): state = IDLE; internal registers cleared (k, N, mode, f, s, ovf). Outputs: in_ready = 1, out_valid = 0, busy = 0, result = 0, overflow = 0. Reset mid-BUSY or mid-DONE aborts the job with no result.
- Internal registers:
  - N, mode: latched operands
  - k: N_W bits
  - f: running factorial, RES_W bits
  - s: running sum, RES_W bits
  - ovf: sticky overflow
- IDLE:
  - If in_valid at the edge: latch n_in and mode_in; f = 1, s = 0, k = 1, ovf = 0.
  - Go to BUSY if n_in ≥ 1, else DONE.
  - in_valid without in_ready is ignored.
- BUSY, one term per edge:
  - f = f·k.
  - s updates by mode: mode 1 s = s + f·k (new f); mode 2 s = s + k; mode 3 s = s + k·k; mode 0 s unchanged.
  - k = k + 1.
  - After the edge that processes k = N: go to DONE.
  - BUSY therefore lasts exactly N cycles.
  - k is N_W bits; N = 2^N_W-1 never wraps k before completion.
- Arithmetic:
  - Products and sums are computed at RES_W+N_W bits.
  - Any bits above RES_W set the sticky ovf and truncate modulo 2^RES_W, or clamp with the optional feature.
  - Overflow in f is flagged only when the mode uses f, i.e. modes 0 and 1.
- DONE:
  - out_valid = 1.
  - result = f for mode 0, s for modes 1–3; overflow = ovf.
  - Held stable until out_ack is sampled high; then go to IDLE.
  - out_ack in any other state is ignored.
  - New input is accepted one cycle after the ack edge (no same-cycle turnaround).
- N = 0: DONE on the acceptance edge. Results: mode 0 → 1, modes 1–3 → 0.
- Latency: out_valid is first visible after edge T0+N, where T0 is the acceptance edge.

Optional Feature:
- SUM_FACT_SATURATE_EN defined: once ovf is set, the accumulator of the active mode clamps to 2^RES_W-1 and stays there. The reported result is all ones.
- Not defined: values wrap modulo 2^RES_W. overflow is reported identically in both builds.

Test Plan:
- Reset, then mode 0, N = 5, in_valid 1 cycle → busy 5 cycles, out_valid after edge T0+5, result = 120, overflow = 0; ack → in_ready 1 next cycle.
- Mode 1, N = 3 → result 9. Mode 2, N = 15 → result 120. Mode 3, N = 4 → result 30. All with overflow = 0.
- Mode 0, N = 0 → out_valid immediately after acceptance edge, result 1. Mode 1, N = 0 → result 0.
- Mode 0, N = 13, RES_W = 32 → overflow = 1. result = 1932053504 without SUM_FACT_SATURATE_EN, 0xFFFFFFFF with it. Mode 1, N = 12 → 522956313, no overflow.
- Hold out_ack low 10 cycles in DONE → result stable, in_ready 0, new in_valid ignored. Pulse out_ack → IDLE, next job accepted.
- Assert reset_n = 0 at third BUSY cycle of mode 0, N = 7 → next cycle IDLE, all outputs at reset values; fresh job N = 3 → result 6.
